axi_wr_chan_demux: RTL and testbench

- AXI4 write-slave control FSM that steers each write burst into one of NUM_CH input FIFOs, e.g. varint, raw-data and further encoders.
- The channel is decoded from the write address.
- Drives per-channel clear/push strobes plus shared registered wdata/wstrb/index, stalls on FIFO full, and returns a B response carrying OKAY or SLVERR.
- Sits between the HPS AXI interconnect and the encoder datapath FIFOs.

---
 rtl/axi_wr_demux_pkg.sv | 30 +++
 rtl/axi_wr_beat_ctr.sv | 40 ++++
 rtl/axi_wr_chan_demux.sv | 142 ++++++++++++++
 tb/tb_axi_wr_chan_demux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_demux_pkg.sv
// Shared types and constants for the AXI write-channel demux.
// The channel field is range-checked at its full 4-bit width so that addresses beyond NUM_CH are flagged.
package axi_wr_demux_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      DATA  = 4'b0010,
      DRAIN = 4'b0100,
      RESP  = 4'b1000
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned CH_FIELD_W = 4;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_wr_beat_ctr.sv
// Beat counter and FIFO index generator for one write burst.
// The index holds in FIXED mode; last flags the beat whose count equals awlen.
module axi_wr_beat_ctr #(
   parameter int unsigned INDEX_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [INDEX_W-1:0] load_idx,
   input  logic [7:0]         load_len,
   input  logic               load_fixed,
   input  logic               inc,
   output logic [INDEX_W-1:0] idx,
   output logic               last
);

   logic [7:0] cnt;
   logic [7:0] len;
   logic       fixed_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         len     <= '0;
         idx     <= '0;
         fixed_q <= 1'b0;
      end else if (load) begin
         cnt     <= '0;
         len     <= load_len;
         idx     <= load_idx;
         fixed_q <= load_fixed;
      end else if (inc) begin
         cnt <= cnt + 8'd1;
         if (!fixed_q) idx <= idx + INDEX_W'(1);
      end
   end

   assign last = (cnt == len);

endmodule

// File: rtl/axi_wr_chan_demux.sv
// AXI4 write slave that steers each burst into one of NUM_CH encoder FIFOs,
// selected by an address field, with SLVERR for illegal or malformed bursts.
module axi_wr_chan_demux
   import axi_wr_demux_pkg::*;
#(
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned ID_W    = 4,
   parameter  int unsigned NUM_CH  = 4,
   parameter  int unsigned CH_LSB  = 12,
   parameter  int unsigned INDEX_W = 10,
   localparam int unsigned STRB_W  = DATA_W / 8,
   localparam int unsigned CH_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ID_W-1:0]    axs_s0_awid,
   input  logic [31:0]        axs_s0_awaddr,
   input  logic [7:0]         axs_s0_awlen,
   input  logic [2:0]         axs_s0_awsize,
   input  logic [1:0]         axs_s0_awburst,
   input  logic               axs_s0_awvalid,
   output logic               axs_s0_awready,
   input  logic [DATA_W-1:0]  axs_s0_wdata,
   input  logic [STRB_W-1:0]  axs_s0_wstrb,
   input  logic               axs_s0_wlast,
   input  logic               axs_s0_wvalid,
   output logic               axs_s0_wready,
   input  logic               axs_s0_bready,
   output logic [ID_W-1:0]    axs_s0_bid,
   output logic [1:0]         axs_s0_bresp,
   output logic               axs_s0_bvalid,
   input  logic [NUM_CH-1:0]  fifo_full,
   output logic [NUM_CH-1:0]  fifo_clr,
   output logic [NUM_CH-1:0]  fifo_push,
   output logic [CH_W-1:0]    ch_sel,
   output logic [DATA_W-1:0]  wdata,
   output logic [STRB_W-1:0]  wstrb,
   output logic [INDEX_W-1:0] index
);

   state_t              state;
   logic [ID_W-1:0]     id_q;
   logic [CH_W-1:0]     ch_q;
   logic                err_q;
   logic [NUM_CH-1:0]   ch_dec;
   logic [NUM_CH-1:0]   aw_dec;
   logic [CH_W-1:0]     aw_ch;
   logic [CH_FIELD_W-1:0] aw_ch_field;
   logic                aw_err;
   logic                aw_off_zero;
   logic                aw_hs;
   logic                beat_hs;
   logic [INDEX_W-1:0]  ctr_idx;
   logic                ctr_last;
   logic                addr_unused;

   assign aw_ch_field = axs_s0_awaddr[CH_LSB +: CH_FIELD_W];
   assign aw_ch       = axs_s0_awaddr[CH_LSB +: CH_W];
   assign aw_off_zero = (axs_s0_awaddr[CH_LSB-1:0] == '0);
   assign aw_err      = (32'(aw_ch_field) >= NUM_CH) || (axs_s0_awburst == BURST_WRAP)
                     || (axs_s0_awsize != 3'(clog2(STRB_W)));
   assign addr_unused = ^{axs_s0_awaddr[1:0], axs_s0_awaddr[31:CH_LSB+CH_FIELD_W]};

   always_comb begin
      ch_dec = '0;
      aw_dec = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_dec[i] = (ch_q == CH_W'(i));
         aw_dec[i] = (aw_ch == CH_W'(i));
      end
   end

   assign axs_s0_awready = (state == IDLE);
   assign axs_s0_bvalid  = (state == RESP);
   assign axs_s0_bid     = id_q;
   assign axs_s0_bresp   = (axs_s0_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
   assign axs_s0_wready  = ((state == DATA) && !(|(fifo_full & ch_dec))) || (state == DRAIN);
   assign aw_hs          = (state == IDLE) && axs_s0_awvalid;
   assign beat_hs        = axs_s0_wvalid && axs_s0_wready;
   assign ch_sel         = ch_q;

   axi_wr_beat_ctr #(.INDEX_W(INDEX_W)) u_beat_ctr (
      .clk        (clk),
      .reset      (reset),
      .load       (aw_hs),
      .load_idx   (axs_s0_awaddr[INDEX_W+1:2]),
      .load_len   (axs_s0_awlen),
      .load_fixed (axs_s0_awburst == BURST_FIXED),
      .inc        (beat_hs),
      .idx        (ctr_idx),
      .last       (ctr_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         id_q      <= '0;
         ch_q      <= '0;
         err_q     <= 1'b0;
         fifo_clr  <= '0;
         fifo_push <= '0;
         wdata     <= '0;
         wstrb     <= '0;
         index     <= '0;
      end else begin
         fifo_clr  <= '0;
         fifo_push <= '0;
         case (state)
            IDLE: begin
               if (axs_s0_awvalid) begin
                  id_q  <= axs_s0_awid;
                  ch_q  <= aw_ch;
                  err_q <= aw_err;
                  state <= aw_err ? DRAIN : DATA;
                  if (!aw_err && aw_off_zero) fifo_clr <= aw_dec;
               end
            end
            DATA, DRAIN: begin
               if (beat_hs) begin
                  if (state == DATA) begin
                     wdata     <= axs_s0_wdata;
                     wstrb     <= axs_s0_wstrb;
                     index     <= ctr_idx;
                     fifo_push <= ch_dec;
                  end
                  // Burst length follows awlen; a misplaced wlast only flags the error.
                  if (axs_s0_wlast != ctr_last) err_q <= 1'b1;
                  if (ctr_last) state <= RESP;
               end
            end
            RESP: begin
               if (axs_s0_bready) begin
                  err_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_chan_demux.sv
// Directed self-checking bench for axi_wr_chan_demux with a push/clear monitor.
module tb_axi_wr_chan_demux;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [31:0] wdata_in;
   logic [3:0]  wstrb_in;
   logic        wlast, wvalid, wready;
   logic        bready, bvalid;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic [3:0]  fifo_full, fifo_clr, fifo_push;
   logic [1:0]  ch_sel;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [9:0]  index;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [3:0]  q_ch[$];
   logic [9:0]  q_idx[$];
   logic [31:0] q_dat[$];
   int          clr_cnt;
   logic [3:0]  clr_val;
   int          clr_cyc;
   int          push_cyc0;

   axi_wr_chan_demux #(.DATA_W(32), .ID_W(4), .NUM_CH(4), .CH_LSB(12), .INDEX_W(10)) dut (
      .clk(clk), .reset(reset),
      .axs_s0_awid(awid), .axs_s0_awaddr(awaddr), .axs_s0_awlen(awlen),
      .axs_s0_awsize(awsize), .axs_s0_awburst(awburst),
      .axs_s0_awvalid(awvalid), .axs_s0_awready(awready),
      .axs_s0_wdata(wdata_in), .axs_s0_wstrb(wstrb_in), .axs_s0_wlast(wlast),
      .axs_s0_wvalid(wvalid), .axs_s0_wready(wready),
      .axs_s0_bready(bready), .axs_s0_bid(bid), .axs_s0_bresp(bresp), .axs_s0_bvalid(bvalid),
      .fifo_full(fifo_full), .fifo_clr(fifo_clr), .fifo_push(fifo_push),
      .ch_sel(ch_sel), .wdata(wdata), .wstrb(wstrb), .index(index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (fifo_clr != 4'b0 || fifo_push != 4'b0)
            check("clr_push_exclusive", {63'd0, (fifo_clr != 4'b0) && (fifo_push != 4'b0)}, 64'd0);
         if (fifo_push != 4'b0) begin
            if (q_ch.size() == 0) push_cyc0 = cyc;
            q_ch.push_back(fifo_push);
            q_idx.push_back(index);
            q_dat.push_back(wdata);
         end
         if (fifo_clr != 4'b0) begin
            clr_cnt++;
            clr_val = fifo_clr;
            clr_cyc = cyc;
         end
      end
   end

   task automatic clear_mon();
      q_ch.delete(); q_idx.delete(); q_dat.delete();
      clr_cnt = 0; clr_val = '0; clr_cyc = 0; push_cyc0 = 0;
   endtask

   task automatic aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                     input logic [3:0] id);
      awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2; awvalid = 1'b1;
      #1;
      check("aw_ready", {63'd0, awready}, 64'd1);
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic [31:0] d, input logic last, output int waited);
      wdata_in = d; wstrb_in = 4'hF; wlast = last; wvalid = 1'b1;
      waited = 0;
      #1;
      while (!wready && waited < 20) begin
         @(posedge clk); #2;
         waited++;
      end
      check("w_handshake_timeout", {63'd0, wready}, 64'd1);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic do_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
      bready = 1'b1;
      for (int i = 0; i < 20 && !bvalid; i++) begin
         @(posedge clk); #1;
      end
      check("b_valid", {63'd0, bvalid}, 64'd1);
      check("b_id", {60'd0, bid}, {60'd0, exp_id});
      check("b_resp", {62'd0, bresp}, {62'd0, exp_resp});
      @(posedge clk); #1;
      bready = 1'b0;
      check("b_back_idle", {62'd0, bvalid, awready}, 64'd1);
   endtask

   initial begin
      int w;
      reset = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
      awvalid = 1'b0; wdata_in = '0; wstrb_in = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; fifo_full = '0;
      clear_mon();
      @(posedge clk); @(posedge clk); #1;
      check("rst_awready", {63'd0, awready}, 64'd1);
      check("rst_outs", {wready, bvalid, bid, bresp, fifo_clr, fifo_push, ch_sel, wstrb, index}, 64'd0);
      check("rst_wdata", {32'd0, wdata}, 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // 1: ch1 offset 0, INCR awlen 3
      aw(32'h1000, 8'd3, 2'b01, 4'd5);
      for (int k = 0; k < 4; k++) wbeat(32'hA0 + k, k == 3, w);
      check("t1_ch_sel", {62'd0, ch_sel}, 64'd1);
      do_b(4'd5, 2'b00);
      check("t1_clr_cnt", 64'(clr_cnt), 64'd1);
      check("t1_clr_val", {60'd0, clr_val}, 64'h2);
      check("t1_clr_before_push", {63'd0, clr_cyc < push_cyc0}, 64'd1);
      check("t1_push_cnt", 64'(q_ch.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_ch%0d", k), {60'd0, q_ch[k]}, 64'h2);
         check($sformatf("t1_idx%0d", k), {54'd0, q_idx[k]}, 64'(k));
         check($sformatf("t1_dat%0d", k), {32'd0, q_dat[k]}, 64'hA0 + 64'(k));
      end
      clear_mon();

      // 2: FIXED at ch2 index 2, no clear
      aw(32'h2008, 8'd2, 2'b00, 4'd3);
      for (int k = 0; k < 3; k++) wbeat(32'hB0 + k, k == 2, w);
      do_b(4'd3, 2'b00);
      check("t2_clr_cnt", 64'(clr_cnt), 64'd0);
      check("t2_push_cnt", 64'(q_ch.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t2_ch%0d", k), {60'd0, q_ch[k]}, 64'h4);
         check($sformatf("t2_idx%0d", k), {54'd0, q_idx[k]}, 64'd2);
         check($sformatf("t2_dat%0d", k), {32'd0, q_dat[k]}, 64'hB0 + 64'(k));
      end
      clear_mon();

      // 3: ch0 stall for 5 cycles mid-burst
      aw(32'h0000, 8'd7, 2'b01, 4'd1);
      wbeat(32'hC0, 1'b0, w);
      wbeat(32'hC1, 1'b0, w);
      fifo_full = 4'b0001; wdata_in = 32'hC2; wstrb_in = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t3_stall%0d", k), {63'd0, wready}, 64'd0);
         @(posedge clk); #1;
      end
      check("t3_push_during_stall", 64'(q_ch.size()), 64'd2);
      fifo_full = 4'b0000;
      wbeat(32'hC2, 1'b0, w);
      check("t3_resume_no_wait", 64'(w), 64'd0);
      for (int k = 3; k < 8; k++) wbeat(32'hC0 + k, k == 7, w);
      do_b(4'd1, 2'b00);
      check("t3_clr_val", {60'd0, clr_val}, 64'h1);
      check("t3_push_cnt", 64'(q_ch.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t3_idx%0d", k), {54'd0, q_idx[k]}, 64'(k));
         check($sformatf("t3_dat%0d", k), {32'd0, q_dat[k]}, 64'hC0 + 64'(k));
      end
      clear_mon();

      // 4: channel 5 out of range, drained
      aw(32'h5000, 8'd1, 2'b01, 4'd7);
      fifo_full = 4'b1111;
      wbeat(32'hD0, 1'b0, w);
      check("t4_drain_wait0", 64'(w), 64'd0);
      wbeat(32'hD1, 1'b1, w);
      check("t4_drain_wait1", 64'(w), 64'd0);
      fifo_full = 4'b0000;
      do_b(4'd7, 2'b10);
      check("t4_push_cnt", 64'(q_ch.size()), 64'd0);
      check("t4_clr_cnt", 64'(clr_cnt), 64'd0);
      clear_mon();

      // 5: early wlast, bready held off 3 cycles
      aw(32'h3004, 8'd3, 2'b01, 4'd9);
      for (int k = 0; k < 4; k++) wbeat(32'hE0 + k, k == 1, w);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5_bhold%0d", k), {61'd0, bvalid, bresp}, 64'h6);
         @(posedge clk); #1;
      end
      do_b(4'd9, 2'b10);
      check("t5_push_cnt", 64'(q_ch.size()), 64'd4);
      check("t5_idx3", {54'd0, q_idx[3]}, 64'd4);
      check("t5_ch0", {60'd0, q_ch[0]}, 64'h8);
      clear_mon();

      // 6: 256-beat burst with index wrap
      aw(32'h1FF0, 8'd255, 2'b01, 4'd6);
      for (int k = 0; k < 256; k++) wbeat(32'(k), k == 255, w);
      do_b(4'd6, 2'b00);
      check("t6_push_cnt", 64'(q_ch.size()), 64'd256);
      check("t6_idx0", {54'd0, q_idx[0]}, 64'd1020);
      check("t6_idx3", {54'd0, q_idx[3]}, 64'd1023);
      check("t6_idx4", {54'd0, q_idx[4]}, 64'd0);
      check("t6_idx255", {54'd0, q_idx[255]}, 64'd251);
      check("t6_dat255", {32'd0, q_dat[255]}, 64'd255);
      clear_mon();

      // 7: reset mid-burst, then single-beat burst
      aw(32'h1000, 8'd3, 2'b01, 4'd2);
      wbeat(32'hF0, 1'b0, w);
      wbeat(32'hF1, 1'b0, w);
      reset = 1'b0;
      #1;
      check("t7_rst_awready", {63'd0, awready}, 64'd1);
      check("t7_rst_outs", {wready, bvalid, bid, bresp, fifo_clr, fifo_push, ch_sel, wstrb, index}, 64'd0);
      check("t7_rst_wdata", {32'd0, wdata}, 64'd0);
      @(negedge clk); reset = 1'b1;
      clear_mon();
      @(posedge clk); #1;
      aw(32'h2000, 8'd0, 2'b01, 4'd4);
      wbeat(32'hD00D, 1'b1, w);
      do_b(4'd4, 2'b00);
      check("t7_clr_val", {60'd0, clr_val}, 64'h4);
      check("t7_push_cnt", 64'(q_ch.size()), 64'd1);
      check("t7_dat", {32'd0, q_dat[0]}, 64'hD00D);
      check("t7_idx", {54'd0, q_idx[0]}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
